// File: rtl/sound_request_scheduler_pkg.sv
// ============================================================================
// Module  : sound_pkg
// Brief   : Shared types and constants for the sound request scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sound_pkg;

  localparam int NUM_SOUNDS = 6;
  localparam int DUR_W      = 10;

  typedef enum logic [2:0] {
    HOLE         = 3'd0,
    BALL_TO_BALL = 3'd1,
    BORDER       = 3'd2,
    KEY_ENTER    = 3'd3,
    KEY_X        = 3'd4,
    KEY_Y        = 3'd5
  } sound_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  // Tone lengths in ms, indexed by sound_id_t.
  localparam logic [DUR_W-1:0] DUR_MS [NUM_SOUNDS] = '{
    10'd400, 10'd60, 10'd80, 10'd150, 10'd40, 10'd40
  };

  // Range-safe lookup: ids outside 0..5 map to zero.
  function automatic logic [DUR_W-1:0] dur_ms_of(input logic [2:0] id);
    dur_ms_of = '0;
    for (int i = 0; i < NUM_SOUNDS; i++) begin
      if (id == 3'(i)) dur_ms_of = DUR_MS[i];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/sound_request_scheduler_if.sv
// ============================================================================
// Module  : sound_request_scheduler_if
// Brief   : Request/status bundle between request mapping and the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sound_request_scheduler_if;
  import sound_pkg::*;

  logic [NUM_SOUNDS-1:0] req;
  logic                  mute;
  logic                  soundEnable;
  logic [2:0]            toneIdx;
  logic                  busy;
  logic [NUM_SOUNDS-1:0] pending;

  modport master (
    output req, mute,
    input  soundEnable, toneIdx, busy, pending
  );

  modport slave (
    input  req, mute,
    output soundEnable, toneIdx, busy, pending
  );

endinterface

`default_nettype wire

// File: rtl/sound_request_scheduler_priority_encoder.sv
// ============================================================================
// Module  : sound_priority_encoder
// Brief   : Fixed-priority picker, lowest set index wins; one-hot mask out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sound_priority_encoder
  import sound_pkg::*;
(
  input  logic [NUM_SOUNDS-1:0] vec_i,
  output logic [2:0]            idx_o,
  output logic                  valid_o,
  output logic [NUM_SOUNDS-1:0] mask_o
);

  assign valid_o = |vec_i;
  // Two's-complement trick isolates the lowest set bit.
  assign mask_o  = vec_i & (~vec_i + 1'b1);

  always_comb begin
    idx_o = 3'd0;
    for (int i = NUM_SOUNDS - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 3'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sound_request_scheduler.sv
// ============================================================================
// Module  : sound_request_scheduler
// Brief   : Serialises six audio request strobes onto one tone generator.
//           Optional abort-on-higher-priority behaviour: SOUND_PREEMPT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sound_request_scheduler
  import sound_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int GAP_MS   = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  sound_request_scheduler_if.slave    bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  sched_state_t          state_q, state_d;
  logic [NUM_SOUNDS-1:0] pending_q, pending_d;
  logic [2:0]            tone_q, tone_d;
  logic [DUR_W-1:0]      dur_q, dur_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  sound_en_q, sound_en_d;
  logic                  busy_q, busy_d;

  logic [2:0]            win_idx;
  logic                  win_valid;
  logic [NUM_SOUNDS-1:0] win_mask;
  logic                  grant_en;
  logic                  tick;

  sound_priority_encoder u_prio (
    .vec_i   (pending_q),
    .idx_o   (win_idx),
    .valid_o (win_valid),
    .mask_o  (win_mask)
  );

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    grant_en = 1'b0;
    if (!bus.mute && win_valid) begin
      if (state_q == IDLE) begin
        grant_en = 1'b1;
      end
`ifdef SOUND_PREEMPT_EN
      else if (win_idx < tone_q) begin
        grant_en = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tone_d     = tone_q;
    dur_d      = dur_q;
    presc_d    = '0;
    sound_en_d = sound_en_q;
    busy_d     = busy_q;
    pending_d  = (pending_q & ~(grant_en ? win_mask : '0)) | bus.req;

    if (state_q == PLAY || state_q == GAP) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        // Final tick of the current phase: a count of 1 here reaches 0.
        if (dur_q <= DUR_W'(1)) begin
          presc_d = '0;
          if (state_q == PLAY) begin
            state_d    = GAP;
            dur_d      = DUR_W'(GAP_MS);
            sound_en_d = 1'b0;
          end else begin
            state_d = IDLE;
            dur_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          dur_d = dur_q - DUR_W'(1);
        end
      end
    end

    if (grant_en) begin
      state_d    = PLAY;
      tone_d     = win_idx;
      dur_d      = dur_ms_of(win_idx);
      presc_d    = '0;
      sound_en_d = 1'b1;
      busy_d     = 1'b1;
    end

    if (bus.mute) begin
      state_d    = IDLE;
      pending_d  = '0;
      dur_d      = '0;
      presc_d    = '0;
      sound_en_d = 1'b0;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      tone_q     <= '0;
      dur_q      <= '0;
      presc_q    <= '0;
      sound_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      tone_q     <= tone_d;
      dur_q      <= dur_d;
      presc_q    <= presc_d;
      sound_en_q <= sound_en_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.soundEnable = sound_en_q;
  assign bus.toneIdx     = tone_q;
  assign bus.busy        = busy_q;
  assign bus.pending     = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_sound_request_scheduler.sv
// ============================================================================
// Module  : tb_sound_request_scheduler
// Brief   : Directed bench for sound_request_scheduler (TICK_DIV=4, GAP_MS=20).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sound_request_scheduler;
  import sound_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sound_request_scheduler_if bus ();

  sound_request_scheduler #(
    .TICK_DIV (4),
    .GAP_MS   (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic se, input logic [2:0] ti,
                           input logic bz, input logic [5:0] pd);
    check({tag, ".soundEnable"}, 32'(bus.soundEnable), 32'(se));
    check({tag, ".toneIdx"},     32'(bus.toneIdx),     32'(ti));
    check({tag, ".busy"},        32'(bus.busy),        32'(bz));
    check({tag, ".pending"},     32'(bus.pending),     32'(pd));
  endtask

  // Drive req for exactly one cycle; returns one cycle later.
  task automatic strobe(input logic [5:0] m);
    bus.req = m;
    step(1);
    bus.req = '0;
  endtask

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.mute = 1'b0;
    step(3);
    check_out("reset", 1'b0, 3'd0, 1'b0, 6'b000000);
    reset = 1'b0;
    step(10);
    check_out("post_reset_idle", 1'b0, 3'd0, 1'b0, 6'b000000);

    // Single keyX strobe: 160 cycles of tone, 80 cycles of gap.
    strobe(6'b010000);
    check_out("x_latched", 1'b0, 3'd0, 1'b0, 6'b010000);
    step(1);
    check_out("x_start", 1'b1, 3'd4, 1'b1, 6'b000000);
    step(159);
    check_out("x_last_tone", 1'b1, 3'd4, 1'b1, 6'b000000);
    step(1);
    check_out("x_gap_start", 1'b0, 3'd4, 1'b1, 6'b000000);
    step(79);
    check_out("x_gap_end", 1'b0, 3'd4, 1'b1, 6'b000000);
    step(1);
    check_out("x_idle", 1'b0, 3'd4, 1'b0, 6'b000000);

    // Simultaneous hole + keyY: hole first, keyY waits.
    strobe(6'b100001);
    check("both_latched", 32'(bus.pending), 32'h21);
    step(1);
    check_out("hole_start", 1'b1, 3'd0, 1'b1, 6'b100000);
    step(1599);
    check_out("hole_last", 1'b1, 3'd0, 1'b1, 6'b100000);
    step(1);
    check_out("hole_gap", 1'b0, 3'd0, 1'b1, 6'b100000);
    step(80);
    check_out("hole_idle", 1'b0, 3'd0, 1'b0, 6'b100000);
    step(1);
    check_out("y_start", 1'b1, 3'd5, 1'b1, 6'b000000);
    step(160);
    check_out("y_gap", 1'b0, 3'd5, 1'b1, 6'b000000);
    step(80);
    check_out("y_idle", 1'b0, 3'd5, 1'b0, 6'b000000);

    // keyEnter re-requested three times while playing: one replay only.
    strobe(6'b001000);
    step(1);
    check_out("enter_start", 1'b1, 3'd3, 1'b1, 6'b000000);
    step(8);
    strobe(6'b001000);
    step(9);
    strobe(6'b001000);
    step(9);
    strobe(6'b001000);
    check_out("enter_merged", 1'b1, 3'd3, 1'b1, 6'b001000);
    step(651);
    check_out("enter_gap_done", 1'b0, 3'd3, 1'b0, 6'b001000);
    step(1);
    check_out("enter_replay", 1'b1, 3'd3, 1'b1, 6'b000000);
    step(690);
    check_out("enter_no_second", 1'b0, 3'd3, 1'b0, 6'b000000);

    // Mute during PLAY flushes pending and silences at the next edge.
    strobe(6'b000010);
    step(1);
    check_out("b2b_start", 1'b1, 3'd1, 1'b1, 6'b000000);
    step(3);
    strobe(6'b010100);
    check_out("b2b_pend", 1'b1, 3'd1, 1'b1, 6'b010100);
    bus.mute = 1'b1;
    step(1);
    check_out("mute_edge", 1'b0, 3'd1, 1'b0, 6'b000000);
    bus.req = 6'b000100;
    step(3);
    bus.req = '0;
    check_out("mute_ignores_req", 1'b0, 3'd1, 1'b0, 6'b000000);
    bus.mute = 1'b0;
    step(10);
    check_out("unmute_idle", 1'b0, 3'd1, 1'b0, 6'b000000);

    // Asynchronous reset in the middle of a border tone.
    strobe(6'b000100);
    step(5);
    check_out("border_play", 1'b1, 3'd2, 1'b1, 6'b000000);
    reset = 1'b1;
    #2;
    check_out("async_reset", 1'b0, 3'd0, 1'b0, 6'b000000);
    step(1);
    reset = 1'b0;
    step(20);
    check_out("after_reset_quiet", 1'b0, 3'd0, 1'b0, 6'b000000);

    // Higher-priority request while a lower one plays.
    strobe(6'b010000);
    step(1);
    check_out("pre_x_start", 1'b1, 3'd4, 1'b1, 6'b000000);
    step(8);
    strobe(6'b000001);
    step(1);
`ifdef SOUND_PREEMPT_EN
    check_out("preempt_hole", 1'b1, 3'd0, 1'b1, 6'b000000);
    step(1599);
    check_out("preempt_hole_last", 1'b1, 3'd0, 1'b1, 6'b000000);
    step(1);
    check_out("preempt_gap", 1'b0, 3'd0, 1'b1, 6'b000000);
    step(90);
    check_out("preempt_no_replay", 1'b0, 3'd0, 1'b0, 6'b000000);
`else
    check_out("wait_hole", 1'b1, 3'd4, 1'b1, 6'b000001);
    step(150);
    check_out("wait_x_gap", 1'b0, 3'd4, 1'b1, 6'b000001);
    step(80);
    check_out("wait_idle", 1'b0, 3'd4, 1'b0, 6'b000001);
    step(1);
    check_out("late_hole", 1'b1, 3'd0, 1'b1, 6'b000000);
    step(1690);
    check_out("late_hole_done", 1'b0, 3'd0, 1'b0, 6'b000000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
